// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with stall, flush and Tnew aging.
// Optional PIPE_STAGE_PERF_EN adds saturating stall/bubble counters.
module pipe_stage_reg #(
    parameter int unsigned NUM_WORDS = 2,
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned TNEW_W    = 3,
    parameter int unsigned TNEW_DEC  = 1,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        flush,
    input  logic                        in_valid,
    input  logic [31:0]                 in_instr,
    input  logic [31:0]                 in_pc,
    input  logic [NUM_WORDS*WORD_W-1:0] in_data,
    input  logic [TNEW_W-1:0]           in_tnew,
    input  logic                        in_jump,
    output logic                        out_valid,
    output logic [31:0]                 out_instr,
    output logic [31:0]                 out_pc,
    output logic [NUM_WORDS*WORD_W-1:0] out_data,
    output logic [TNEW_W-1:0]           out_tnew,
    output logic                        out_jump
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [15:0]                 stall_cnt,
    output logic [15:0]                 bubble_cnt
`endif
);

    logic                        r_valid;
    logic [31:0]                 r_instr;
    logic [31:0]                 r_pc;
    logic [NUM_WORDS*WORD_W-1:0] r_data;
    logic [TNEW_W-1:0]           r_tnew;
    logic                        r_jump;

    logic [TNEW_W-1:0]           w_tnew_next;
    logic                        w_bubble;

    // Saturating decrement; a zero decrement is a plain pass-through.
    generate
        if (TNEW_DEC == 0) begin : g_tnew_pass
            assign w_tnew_next = in_tnew;
        end else begin : g_tnew_dec
            assign w_tnew_next = (32'(in_tnew) >= TNEW_DEC) ?
                                 TNEW_W'(32'(in_tnew) - TNEW_DEC) : '0;
        end
    endgenerate

    assign w_bubble = flush | (en & ~in_valid);

    // A bubble keeps the slot PC so exception/debug tracking stays aligned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
            r_data  <= '0;
            r_tnew  <= '0;
            r_jump  <= 1'b0;
        end else if (w_bubble) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc    <= in_pc;
            r_data  <= '0;
            r_tnew  <= '0;
            r_jump  <= 1'b0;
        end else if (en) begin
            r_valid <= 1'b1;
            r_instr <= in_instr;
            r_pc    <= in_pc;
            r_data  <= in_data;
            r_tnew  <= w_tnew_next;
            r_jump  <= in_jump;
        end
    end

    assign out_valid = r_valid;
    assign out_instr = r_instr;
    assign out_pc    = r_pc;
    assign out_data  = r_data;
    assign out_tnew  = r_tnew;
    assign out_jump  = r_jump;

`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_bubble_cnt;
    logic        w_stall_edge;

    assign w_stall_edge = ~flush & ~en & r_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_stall_edge && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_bubble && (r_bubble_cnt != 16'hFFFF))
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised bench for pipe_stage_reg checked against a rule-level model;
// three instances cover TNEW_DEC = 1, 2 and 0. Perf checks run with PIPE_STAGE_PERF_EN.
module tb_pipe_stage_reg;
  localparam int DW    = 64;
  localparam int OBS_W = 1 + 1 + 3 + 32 + 32 + DW + 3 + 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          en, flush, in_valid, in_jump;
  logic [31:0]   in_instr, in_pc;
  logic [DW-1:0] in_data;
  logic [2:0]    in_tnew;

  logic          out_valid, out_jump;
  logic [31:0]   out_instr, out_pc;
  logic [DW-1:0] out_data;
  logic [2:0]    out_tnew;

  logic          d2_valid, d2_jump, d0_valid, d0_jump;
  logic [31:0]   d2_instr, d2_pc, d0_instr, d0_pc;
  logic [DW-1:0] d2_data, d0_data;
  logic [2:0]    d2_tnew, d0_tnew;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0]   stall_cnt, bubble_cnt, d2_sc, d2_bc, d0_sc, d0_bc;
`endif

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  logic          m_valid, m_jump;
  logic [31:0]   m_instr, m_pc;
  logic [DW-1:0] m_data;
  logic [2:0]    m_tnew1, m_tnew2, m_tnew0;
  int            m_stall, m_bubble;

  logic [OBS_W-1:0] exp_q[$];
  logic [OBS_W-1:0] obs;
  logic [OBS_W-1:0] want;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
    .in_instr(in_instr), .in_pc(in_pc), .in_data(in_data), .in_tnew(in_tnew),
    .in_jump(in_jump), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .out_data(out_data), .out_tnew(out_tnew), .out_jump(out_jump)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  pipe_stage_reg #(.TNEW_DEC(2)) dut_d2 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
    .in_instr(in_instr), .in_pc(in_pc), .in_data(in_data), .in_tnew(in_tnew),
    .in_jump(in_jump), .out_valid(d2_valid), .out_instr(d2_instr),
    .out_pc(d2_pc), .out_data(d2_data), .out_tnew(d2_tnew), .out_jump(d2_jump)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(d2_sc), .bubble_cnt(d2_bc)
`endif
  );

  pipe_stage_reg #(.TNEW_DEC(0)) dut_d0 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
    .in_instr(in_instr), .in_pc(in_pc), .in_data(in_data), .in_tnew(in_tnew),
    .in_jump(in_jump), .out_valid(d0_valid), .out_instr(d0_instr),
    .out_pc(d0_pc), .out_data(d0_data), .out_tnew(d0_tnew), .out_jump(d0_jump)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(d0_sc), .bubble_cnt(d0_bc)
`endif
  );

  assign obs = {out_valid, out_jump, out_tnew, out_instr, out_pc, out_data, d2_tnew, d0_tnew};

  function automatic logic [2:0] tnew_after(int t, int d);
    return (t > d) ? 3'(t - d) : 3'd0;
  endfunction

  function automatic logic [OBS_W-1:0] exp_vec();
    return {m_valid, m_jump, m_tnew1, m_instr, m_pc, m_data, m_tnew2, m_tnew0};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_jump = 1'b0; m_instr = 32'h0; m_pc = 32'h0; m_data = '0;
    m_tnew1 = 3'd0; m_tnew2 = 3'd0; m_tnew0 = 3'd0;
    m_stall = 0; m_bubble = 0;
  endtask

  // Applies the edge rules to the current inputs (call before the edge).
  task automatic model_edge();
    if (flush || (en && !in_valid)) begin
      m_valid = 1'b0; m_jump = 1'b0; m_instr = 32'h0; m_data = '0;
      m_tnew1 = 3'd0; m_tnew2 = 3'd0; m_tnew0 = 3'd0; m_pc = in_pc;
      if (m_bubble < 65535) m_bubble++;
    end else if (en) begin
      m_valid = 1'b1; m_jump = in_jump; m_instr = in_instr; m_pc = in_pc; m_data = in_data;
      m_tnew1 = tnew_after(int'(in_tnew), 1);
      m_tnew2 = tnew_after(int'(in_tnew), 2);
      m_tnew0 = tnew_after(int'(in_tnew), 0);
    end else if (m_valid && m_stall < 65535) begin
      m_stall++;
    end
  endtask

  task automatic drive(input logic e, input logic f, input logic v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic [DW-1:0] d, input logic [2:0] t,
                       input logic j);
    en = e; flush = f; in_valid = v; in_instr = ins; in_pc = pc;
    in_data = d; in_tnew = t; in_jump = j;
  endtask

  task automatic drive_random(input logic e, input logic f, input logic v);
    drive(e, f, v, $urandom, $urandom, {$urandom, $urandom},
          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_random(1'b1, 1'b0, 1'b1);
    model_reset();
    repeat (2) @(negedge clk);
    n_total++;
    if (obs !== exp_vec()) begin
      n_bad++; $display("FAIL reset_hold: got %h expected %h", obs, exp_vec());
    end
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h0000_1000, {32'h1, 32'h2}, 3'd4, 1'b1);
    tick();
    n_total++;
    if (obs !== exp_vec()) begin
      n_bad++; $display("FAIL reset_load: got %h expected %h", obs, exp_vec());
    end
    // assert reset between edges: outputs must clear without a clock edge
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_2000, '1, 3'd7, 1'b1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_total++;
    if (obs !== exp_vec()) begin
      n_bad++; $display("FAIL reset_async: got %h expected %h", obs, exp_vec());
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_advance();
    drive(1'b1, 1'b0, 1'b1, 32'h0109_5020, 32'h0000_3004,
          {32'hDEAD_BEEF, 32'h0000_0007}, 3'd2, 1'b1);
    tick();
    n_total++;
    if (obs !== exp_vec()) begin
      n_bad++; $display("FAIL advance: got %h expected %h", obs, exp_vec());
    end
    n_total++;
    if ({out_tnew, out_data[63:32], out_data[31:0]} !== {3'd1, 32'hDEAD_BEEF, 32'h0000_0007}) begin
      n_bad++; $display("FAIL advance_fixed: got %h expected %h",
                        {out_tnew, out_data}, {3'd1, 32'hDEAD_BEEF, 32'h0000_0007});
    end
  endtask

  task automatic test_tnew_sat();
    int tv[4] = '{0, 1, 5, 7};
    foreach (tv[i]) begin
      drive(1'b1, 1'b0, 1'b1, $urandom, $urandom, {$urandom, $urandom}, 3'(tv[i]), 1'b0);
      tick();
      n_total++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL tnew_sat_%0d: got %h expected %h", tv[i], obs, exp_vec());
      end
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b0, 1'b1, 32'h0109_5020, 32'h0000_3004,
          {32'hDEAD_BEEF, 32'h0000_0007}, 3'd2, 1'b1);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive_random(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      tick();
      n_total++;
      if (obs !== exp_vec() || out_tnew !== 3'd1) begin
        n_bad++; $display("FAIL stall_%0d: got %h expected %h", c, obs, exp_vec());
      end
    end
    drive_random(1'b1, 1'b0, 1'b1);
    tick();
    n_total++;
    if (obs !== exp_vec()) begin
      n_bad++; $display("FAIL stall_release: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_flush_over_stall();
    drive_random(1'b0, 1'b1, 1'b1);
    in_pc = 32'h0000_3010;
    tick();
    n_total++;
    if (obs !== exp_vec() || out_pc !== 32'h0000_3010) begin
      n_bad++; $display("FAIL flush_over_stall: got %h expected %h", obs, exp_vec());
    end
    drive_random(1'b1, 1'b0, 1'b0);
    tick();
    n_total++;
    if (obs !== exp_vec()) begin
      n_bad++; $display("FAIL invalid_advance: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 300; c++) begin
      drive_random(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                   1'($urandom_range(0, 3) != 0));
      model_edge();
      exp_q.push_back(exp_vec());
      @(posedge clk);
      @(negedge clk);
      want = exp_q.pop_front();
      n_total++;
      if (obs !== want) begin
        n_bad++; $display("FAIL random_%0d: got %h expected %h", c, obs, want);
      end
    end
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    reset = 1'b0; #1; model_reset();
    @(negedge clk); reset = 1'b1;
    drive_random(1'b1, 1'b0, 1'b1);
    tick();
    repeat (4) begin drive_random(1'b0, 1'b0, 1'b1); tick(); end
    repeat (2) begin drive_random(1'b0, 1'b1, 1'b1); tick(); end
    n_total++;
    if (stall_cnt !== 16'd4 || bubble_cnt !== 16'd2) begin
      n_bad++; $display("FAIL perf_counts: got %0d/%0d expected 4/2", stall_cnt, bubble_cnt);
    end
    drive_random(1'b1, 1'b0, 1'b1);
    tick();
    repeat (65540) begin drive_random(1'b0, 1'b0, 1'b1); tick(); end
    n_total++;
    if (stall_cnt !== 16'hFFFF || int'(stall_cnt) !== m_stall) begin
      n_bad++; $display("FAIL perf_sat: got %h expected %h", stall_cnt, 16'(m_stall));
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, '0, 3'd0, 1'b0);
    @(negedge clk);
    test_reset();
    test_advance();
    test_tnew_sat();
    test_stall();
    test_flush_over_stall();
    test_back_to_back();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the 5-stage MIPS core; a generic successor to the fixed EX/MEM latch.
- Carries instruction, PC, N payload words, a jump flag and the hazard-unit Tnew countdown, plus a valid bit.
- Supports stall (hold), flush (bubble injection) and a configurable Tnew decrement.
- One instance is placed between each pair of stages (D/E, E/M, M/W).

Parameters:
- NUM_WORDS, 2, number of WORD_W-bit payload words carried besides instr/pc (e.g. ALU result, rt data).
- WORD_W, 32, payload word width.
- TNEW_W, 3, width of the Tnew field.
- TNEW_DEC, 1, amount subtracted from Tnew on each transfer (0 means pass-through).
- NOP_INSTR, 32'h0000_0000, instruction word loaded on bubble/reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- en  in  1  advance; 1 = load inputs, 0 = hold (stall).
- flush  in  1  load a bubble on the next edge, regardless of en.
- in_valid  in  1  upstream slot holds a real instruction.
- in_instr  in  32  upstream instruction.
- in_pc  in  32  upstream PC.
- in_data  in  NUM_WORDS*WORD_W  payload; word k is at bits [k*WORD_W +: WORD_W].
- in_tnew  in  TNEW_W  cycles until upstream result is ready.
- in_jump  in  1  upstream jump/branch-taken flag.
- out_valid  out  1  registered valid.
- out_instr  out  32  registered instruction.
- out_pc  out  32  registered PC.
- out_data  out  NUM_WORDS*WORD_W  registered payload.
- out_tnew  out  TNEW_W  registered, decremented Tnew.
- out_jump  out  1  registered jump flag.

Behaviour:
- Reset (reset==0, async):
  - out_valid=0, out_instr=NOP_INSTR, out_pc=0, out_data=0, out_tnew=0, out_jump=0.
  - Every output has a defined reset value; no uninitialised fields.
- Priority per rising edge: reset > flush > en > hold.
- Flush (flush=1): load a bubble. Fields equal their reset values, except out_pc = in_pc, so exception and debug tracking keep the slot PC. Flush overrides en=0.
- Advance (flush=0, en=1):
  - All fields load from inputs; out_valid = in_valid.
  - out_tnew = (in_tnew >= TNEW_DEC) ? in_tnew - TNEW_DEC : 0. Saturates at 0 and never wraps.
  - If in_valid=0, the stage loads as a bubble: out_instr=NOP_INSTR, out_tnew=0, out_jump=0, out_data=0. in_pc is still captured.
- Hold (flush=0, en=0): all outputs keep their value. Tnew does not age while stalled.
- Latency: exactly 1 cycle from input to output on advance. No combinational path from any input to any output.
- Reset asserted mid-stall or mid-flush clears the stage immediately (async). The first edge after release behaves per the priority rules.
- TNEW_DEC=0: out_tnew = in_tnew on advance.
- All payload words are treated identically. Word ordering is preserved exactly.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- When defined, two extra output ports are added:
  - stall_cnt (out, 16): saturating count of edges with reset==1, flush=0, en=0 and out_valid=1.
  - bubble_cnt (out, 16): saturating count of edges that load a bubble (flush=1, or en=1 with in_valid=0).
  - Both counters clear on reset, stop at 16'hFFFF and never wrap.
- When undefined, these ports and their logic are absent, and the port list is exactly as above.

Test Plan:
- Reset: drive reset=0 for 2 cycles with random inputs -> out_valid=0, out_instr=0, out_data=0, out_tnew=0, out_jump=0; outputs change without waiting for a clk edge.
- Advance: en=1, in_valid=1, in_instr=32'h0109_5020, in_pc=32'h0000_3004, in_data={32'hDEAD_BEEF, 32'h0000_0007}, in_tnew=2, in_jump=1 -> after one edge, outputs match the inputs, with out_tnew=1 and out_valid=1.
- Tnew saturation: in_tnew=0 with TNEW_DEC=1 -> out_tnew=0. Instance with TNEW_DEC=2, in_tnew=1 -> 0; in_tnew=5 -> 3.
- Stall: load as in the Advance test, then en=0 for 3 cycles with different inputs -> outputs unchanged, out_tnew stays 1. Then en=1 -> new values captured.
- Flush over stall: en=0, flush=1, in_pc=32'h0000_3010 -> out_valid=0, out_instr=0, out_tnew=0, out_jump=0, out_pc=32'h0000_3010.
- Perf (PIPE_STAGE_PERF_EN defined): 4 stall edges on a valid stage plus 2 flushes -> stall_cnt=4, bubble_cnt=2. Forcing stall_cnt to 16'hFFFF then stalling again -> stays 16'hFFFF.
